// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: runs WIDTH-bit {mode,opcode} operations one bit per clock, LSB first.
// Optional LOGIC_FAST_EN: mode 00 (logic) ops bypass the serial loop and finish in one cycle.
module alu_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_sh, res_sh_d, result_d;
  logic [3:0]       op_q, op_d, op_in;
  logic [CW-1:0]    cnt, cnt_d;
  logic             carry, carry_d;
  logic             busy_d, done_d, err_d, cout_d;
  logic             x_bit, y_bit, s_bit, c_next;

  assign op_in = {mode, opcode};

  // 1-bit slice: X = A or ~A, Y = B or 0; logic ops are X^Y with the carry chain held at 0
  always_comb begin
    x_bit  = a_q[0] ^ op_q[0];
    y_bit  = b_q[0] & op_q[1];
    s_bit  = x_bit ^ y_bit ^ carry;
    c_next = (op_q[3:2] != 2'b00) &
             ((x_bit & y_bit) | (x_bit & carry) | (y_bit & carry));
  end

  // Next-state and next-register values
  always_comb begin
    state_d  = state;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt;
    carry_d  = carry;
    res_sh_d = res_sh;
    result_d = result;
    cout_d   = cout;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (op_in[3:2] == 2'b11) begin
            err_d = 1'b1;
          end else begin
            a_d      = a;
            b_d      = b;
            op_d     = op_in;
            carry_d  = op_in[3];
            cnt_d    = '0;
            res_sh_d = '0;
            state_d  = RUN;
`ifdef LOGIC_FAST_EN
            if (op_in[3:2] == 2'b00) begin
              result_d = (a ^ {WIDTH{op_in[0]}}) ^ (b & {WIDTH{op_in[1]}});
              cout_d   = 1'b0;
              done_d   = 1'b1;
              state_d  = DONE;
            end
`endif
          end
        end
      end
      RUN: begin
        res_sh_d = {s_bit, res_sh[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        carry_d  = c_next;
        cnt_d    = cnt + CW'(1);
        // Final bit: publish the word and carry as DONE is entered
        if (cnt == CW'(WIDTH - 1)) begin
          result_d = {s_bit, res_sh[WIDTH-1:1]};
          cout_d   = c_next;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      res_sh <= '0;
      result <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      cnt    <= cnt_d;
      carry  <= carry_d;
      res_sh <= res_sh_d;
      result <= result_d;
      cout   <= cout_d;
      busy   <= busy_d;
      done   <= done_d;
      err    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl (WIDTH=8) with a cycle-level reference model and literal checks.
module tb_alu_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [1:0] opcode = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, cout, err;
  logic [7:0] result;

  int vectors = 0;
  int miscompares = 0;

  alu_serial_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .opcode(opcode),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level reference: {cout, result}
  function automatic logic [8:0] ref_op(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] x, y;
    logic [8:0] s;
    if (op[3:2] == 2'b00) begin
      case (op[1:0])
        2'd0:    return {1'b0, av};
        2'd1:    return {1'b0, ~av};
        2'd2:    return {1'b0, av ^ bv};
        default: return {1'b0, ~(av ^ bv)};
      endcase
    end
    x = op[0] ? ~av : av;
    y = op[1] ? bv : 8'h00;
    s = {1'b0, x} + {1'b0, y} + 9'(op[3]);
    return s;
  endfunction

  function automatic int lat(input logic [3:0] op);
`ifdef LOGIC_FAST_EN
    if (op[3:2] == 2'b00) return 1;
`endif
    return 9;
  endfunction

  // Cycle model: m_rem counts remaining busy cycles; the last one is the done cycle
  int         m_rem = 0;
  logic       m_err = 1'b0;
  logic [8:0] m_pend = '0;
  logic [8:0] m_out = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_err = 1'b0; m_pend = '0; m_out = '0;
    end else begin
      m_err = 1'b0;
      if (m_rem == 0) begin
        if (start) begin
          if (mode == 2'b11) m_err = 1'b1;
          else begin
            m_rem  = lat({mode, opcode});
            m_pend = ref_op({mode, opcode}, a, b);
          end
        end
      end else begin
        m_rem--;
      end
      if (m_rem == 1) m_out = m_pend;
    end
  end

  always @(negedge clk) begin
    chk("busy",   32'(busy),   32'(m_rem != 0));
    chk("done",   32'(done),   32'(m_rem == 1));
    chk("err",    32'(err),    32'(m_err));
    chk("result", 32'(result), 32'(m_out[7:0]));
    chk("cout",   32'(cout),   32'(m_out[8]));
  end

  // Issue one op, scramble the inputs while busy, and check latency, busy length and literal result
  task automatic do_op(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] er, input logic ec);
    int bc, done_at;
    chk("model_pin", 32'(ref_op(op, av, bv)), 32'({ec, er}));
    @(posedge clk); #2;
    start = 1'b1; {mode, opcode} = op; a = av; b = bv;
    @(posedge clk); #2;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); {mode, opcode} = 4'($urandom);
    bc = 0; done_at = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        done_at = i;
        chk("op_result", 32'(result), 32'(er));
        chk("op_cout",   32'(cout),   32'(ec));
      end
      if (!busy) break;
    end
    chk("done_latency", 32'(done_at), 32'(lat(op)));
    chk("busy_cycles",  32'(bc),      32'(lat(op)));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_result", 32'(result), 32'd0);

    do_op(4'b0110, 8'hC8, 8'h64, 8'h2C, 1'b1);
    do_op(4'b1011, 8'h05, 8'h03, 8'hFE, 1'b0);
    do_op(4'b1011, 8'h03, 8'h05, 8'h02, 1'b1);
    do_op(4'b1001, 8'h00, 8'h5A, 8'h00, 1'b1);
    do_op(4'b1001, 8'h01, 8'h00, 8'hFF, 1'b0);
    do_op(4'b1000, 8'hFF, 8'h00, 8'h00, 1'b1);
    do_op(4'b0011, 8'hA5, 8'h0F, 8'h55, 1'b0);
    do_op(4'b0001, 8'h3C, 8'hFF, 8'hC3, 1'b0);
    do_op(4'b0111, 8'h0F, 8'h10, 8'h00, 1'b1);

    // Extra starts in cycle 3 (RUN) and cycle 9 (done cycle) must be ignored
    @(posedge clk); #2;
    start = 1'b1; {mode, opcode} = 4'b0110; a = 8'hC8; b = 8'h64;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #2;
      start = (cyc == 3 || cyc == 9);
      a = 8'h11; b = 8'h22; {mode, opcode} = 4'b1010;
      @(negedge clk);
      if (cyc == 9) begin
        chk("hs_done",   32'(done),   32'd1);
        chk("hs_result", 32'(result), 32'h2C);
      end
    end
    chk("hs_hold", 32'(result), 32'h2C);

    // Illegal op: err pulse, no busy, result held
    @(posedge clk); #2;
    start = 1'b1; {mode, opcode} = 4'b1100; a = 8'h77;
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    chk("ill_err",    32'(err),    32'd1);
    chk("ill_busy",   32'(busy),   32'd0);
    chk("ill_result", 32'(result), 32'h2C);
    @(negedge clk);
    chk("ill_err_pulse", 32'(err), 32'd0);

    // Async reset in the middle of bit 4
    @(posedge clk); #2;
    start = 1'b1; {mode, opcode} = 4'b0110; a = 8'hC8; b = 8'h64;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",   32'(busy),   32'd0);
    chk("arst_done",   32'(done),   32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_cout",   32'(cout),   32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    do_op(4'b0111, 8'h0F, 8'h10, 8'h00, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
